nw_trace_ctrl: RTL and testbench



---
 rtl/nw_trace_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_nw_trace_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nw_trace_ctrl.sv
// nw_trace_ctrl -- Needleman-Wunsch traceback controller.
//
// Purpose: accepts an alignment job (two strings), starts the scoring grid,
// waits for the final score, then walks the direction matrix from the
// bottom-right cell (LENGTH-1, LENGTH-1) back to (0, 0). Each visited
// coordinate is written to a path memory as {y, x} at consecutive addresses.
//
// Optional feature (compile-time macro NW_TRACE_TIMEOUT_EN): a watchdog on
// the RUN state. If the grid does not report valid within TIMEOUT_CYCLES
// cycles, the job is dropped and error pulses for one cycle. Without the
// macro the watchdog is absent, error is tied low, and RUN waits forever.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   job_valid/job_ready job handshake; ready only while idle
//   s1_in, s2_in        input strings, captured on job acceptance
//   grid_s1, grid_s2    registered strings driven to the grid
//   grid_start          one-cycle start pulse to the grid
//   grid_valid          grid bottom-right cell valid
//   grid_score          grid final score (signed)
//   dir_x, dir_y        direction-matrix read coordinate
//   dir_data            direction of (dir_x, dir_y), one cycle after request
//   wen, waddr, wdata   path memory write port, wdata = {y, x}
//   done                one-cycle completion pulse
//   error               one-cycle watchdog timeout pulse
//   path_len            number of coordinates written by the last job
//   score               score of the last completed job (signed)

module nw_trace_ctrl #(
  parameter int         LENGTH         = 10,
  parameter int         CWIDTH         = 2,
  parameter int         SWIDTH         = 16,
  parameter int         CORD_LENGTH    = 8,
  parameter int         ADDR_SIZE      = 9,
  parameter logic [1:0] TOP_DIR        = 2'b00,
  parameter logic [1:0] LEFT_DIR       = 2'b01,
  parameter logic [1:0] CORNER_DIR     = 2'b10,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [LENGTH*CWIDTH-1:0]   s1_in,
  input  logic [LENGTH*CWIDTH-1:0]   s2_in,
  output logic [LENGTH*CWIDTH-1:0]   grid_s1,
  output logic [LENGTH*CWIDTH-1:0]   grid_s2,
  output logic                       grid_start,
  input  logic                       grid_valid,
  input  logic signed [SWIDTH-1:0]   grid_score,
  output logic [CORD_LENGTH-1:0]     dir_x,
  output logic [CORD_LENGTH-1:0]     dir_y,
  input  logic [1:0]                 dir_data,
  output logic                       wen,
  output logic [ADDR_SIZE-1:0]       waddr,
  output logic [2*CORD_LENGTH-1:0]   wdata,
  output logic                       done,
  output logic                       error,
  output logic [ADDR_SIZE-1:0]       path_len,
  output logic signed [SWIDTH-1:0]   score
);

  // The longest path (2*LENGTH-1 cells) must fit the write address space,
  // and the watchdog limit must be a positive cycle count.
  if ((2*LENGTH-1 > (1 << ADDR_SIZE)) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("nw_trace_ctrl: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_RUN        = 3'd2,
    ST_TRACE_REQ  = 3'd3,
    ST_TRACE_WAIT = 3'd4,
    ST_WRITE      = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  localparam logic [CORD_LENGTH-1:0] LAST_CORD = CORD_LENGTH'(LENGTH-1);

  state_t                     state_q, state_d;
  logic [LENGTH*CWIDTH-1:0]   s1_q, s2_q;
  logic [CORD_LENGTH-1:0]     x_q, y_q;
  logic [CORD_LENGTH-1:0]     x_step, y_step;
  logic [1:0]                 dir_q;
  logic [1:0]                 eff_dir;
  logic [ADDR_SIZE-1:0]       waddr_q;
  logic [ADDR_SIZE-1:0]       path_len_q;
  logic signed [SWIDTH-1:0]   run_score_q;
  logic signed [SWIDTH-1:0]   score_q;
  logic                       at_origin;
  logic                       timeout_hit;

  assign at_origin = (x_q == '0) && (y_q == '0);

`ifdef NW_TRACE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          error_q;

  // The counter holds the number of RUN cycles already elapsed, so the
  // TIMEOUT_CYCLES-th RUN cycle without grid_valid is the one that bails out.
  assign timeout_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (state_q == ST_LOAD) begin
        tmo_cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
        if (!grid_valid && timeout_hit) error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (job_valid) state_d = ST_LOAD;
      ST_LOAD:       state_d = ST_RUN;
      ST_RUN: begin
        if (grid_valid)       state_d = ST_TRACE_REQ;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_TRACE_REQ:  state_d = ST_TRACE_WAIT;
      ST_TRACE_WAIT: state_d = ST_WRITE;
      ST_WRITE:      state_d = at_origin ? ST_DONE : ST_TRACE_REQ;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    job_ready  = (state_q == ST_IDLE);
    grid_start = (state_q == ST_LOAD);
    wen        = (state_q == ST_WRITE);
    done       = (state_q == ST_DONE);
  end

  // On the grid edges only one move is legal, so the stored direction is
  // overridden there; this also keeps the coordinates from wrapping below 0.
  always_comb begin
    eff_dir = dir_q;
    if (y_q == '0)      eff_dir = LEFT_DIR;
    else if (x_q == '0) eff_dir = TOP_DIR;

    x_step = x_q;
    y_step = y_q;
    case (eff_dir)
      TOP_DIR:  y_step = y_q - 1'b1;
      LEFT_DIR: x_step = x_q - 1'b1;
      default: begin
        x_step = x_q - 1'b1;
        y_step = y_q - 1'b1;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dir_q       <= TOP_DIR;
      waddr_q     <= '0;
      path_len_q  <= '0;
      run_score_q <= '0;
      score_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (job_valid) begin
            s1_q <= s1_in;
            s2_q <= s2_in;
          end
        end
        ST_RUN: begin
          if (grid_valid) begin
            // Held privately until DONE so the published score only
            // changes when a job actually completes.
            run_score_q <= grid_score;
            x_q         <= LAST_CORD;
            y_q         <= LAST_CORD;
            waddr_q     <= '0;
          end
        end
        ST_TRACE_WAIT: dir_q <= dir_data;
        ST_WRITE: begin
          waddr_q <= waddr_q + 1'b1;
          if (at_origin) begin
            path_len_q <= waddr_q + 1'b1;
            score_q    <= run_score_q;
          end else begin
            x_q <= x_step;
            y_q <= y_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign grid_s1  = s1_q;
  assign grid_s2  = s2_q;
  assign dir_x    = x_q;
  assign dir_y    = y_q;
  assign waddr    = waddr_q;
  assign wdata    = {y_q, x_q};
  assign path_len = path_len_q;
  assign score    = score_q;

endmodule

// File: tb/tb_nw_trace_ctrl.sv
// Directed testbench for nw_trace_ctrl with LENGTH = 4: corner-only and
// left-only direction fields, job_valid held during a trace, reset in the
// middle of a trace, and the RUN watchdog (when NW_TRACE_TIMEOUT_EN is set).

module tb_nw_trace_ctrl;

  localparam int LENGTH = 4;
  localparam int CWIDTH = 2;
  localparam int SW     = 16;
  localparam int CL     = 8;
  localparam int AW     = 9;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     job_valid;
  logic                     job_ready;
  logic [LENGTH*CWIDTH-1:0] s1_in, s2_in, grid_s1, grid_s2;
  logic                     grid_start;
  logic                     grid_valid;
  logic [SW-1:0]            grid_score;
  logic [CL-1:0]            dir_x, dir_y;
  logic [1:0]               dir_data;
  logic                     wen;
  logic [AW-1:0]            waddr;
  logic [2*CL-1:0]          wdata;
  logic                     done;
  logic                     error;
  logic [AW-1:0]            path_len;
  logic [SW-1:0]            score;

  int checks   = 0;
  int failures = 0;

  // Direction field model: constant direction inside the 4x4 grid, read
  // with one cycle of latency. Out-of-range coordinates answer TOP so that
  // a bad read coordinate perturbs the path.
  logic [1:0] dir_mode;
  always @(posedge clk)
    dir_data <= (dir_x < 8'd4 && dir_y < 8'd4) ? dir_mode : 2'b00;

  always #5 clk = ~clk;

  nw_trace_ctrl #(
    .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SW), .CORD_LENGTH(CL),
    .ADDR_SIZE(AW), .TOP_DIR(2'b00), .LEFT_DIR(2'b01), .CORNER_DIR(2'b10),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .s1_in(s1_in), .s2_in(s2_in), .grid_s1(grid_s1), .grid_s2(grid_s2),
    .grid_start(grid_start), .grid_valid(grid_valid), .grid_score(grid_score),
    .dir_x(dir_x), .dir_y(dir_y), .dir_data(dir_data), .wen(wen),
    .waddr(waddr), .wdata(wdata), .done(done), .error(error),
    .path_len(path_len), .score(score)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Capture of one trace: writes, their cycle offsets, and the done cycle.
  logic [AW-1:0]   wr_addr [16];
  logic [2*CL-1:0] wr_data [16];
  int              wr_cyc  [16];
  int              n_wr, done_cyc, gs_seen, jr_seen;

  // Starts at the negedge where the controller is in RUN with grid_valid
  // already driven; cycle 1 is the first cycle after RUN.
  task automatic run_trace(input int budget);
    n_wr = 0; done_cyc = -1; gs_seen = 0; jr_seen = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) grid_valid = 1'b0;
      if (wen && n_wr < 16) begin
        wr_addr[n_wr] = waddr;
        wr_data[n_wr] = wdata;
        wr_cyc[n_wr]  = c;
        n_wr++;
      end
      if (grid_start) gs_seen++;
      if (job_ready && !done) jr_seen++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  // Offers a job from IDLE and walks through LOAD into RUN.
  task automatic start_job(input logic [7:0] s1, input logic [7:0] s2, input bit hold);
    job_valid = 1'b1;
    s1_in = s1;
    s2_in = s2;
    @(negedge clk);
    chk("load_grid_start", grid_start, 1);
    chk("load_job_ready", job_ready, 0);
    chk("load_grid_s1", grid_s1, s1);
    chk("load_grid_s2", grid_s2, s2);
    if (!hold) job_valid = 1'b0;
    @(negedge clk);
    chk("run_grid_start", grid_start, 0);
  endtask

  logic [15:0] exp_corner [4] = '{16'h0303, 16'h0202, 16'h0101, 16'h0000};
  logic [15:0] exp_left   [7] = '{16'h0303, 16'h0302, 16'h0301, 16'h0300,
                                  16'h0200, 16'h0100, 16'h0000};
  int err_cyc, bad_cnt;

  initial begin
    reset = 1'b0; job_valid = 1'b0; s1_in = '0; s2_in = '0;
    grid_valid = 1'b0; grid_score = '0; dir_mode = 2'b10;

    // ---- reset values ----
    repeat (3) @(negedge clk);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_grid_start", grid_start, 0);
    chk("rst_wen", wen, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_path_len", path_len, 0);
    chk("rst_score", score, 0);
    chk("rst_dir_xy", {dir_y, dir_x}, 0);
    chk("rst_grid_s", {grid_s1, grid_s2}, 0);
    reset = 1'b1;

    // ---- grid_valid while idle is ignored ----
    @(negedge clk);
    grid_valid = 1'b1;
    @(negedge clk);
    chk("idle_gv_job_ready", job_ready, 1);
    chk("idle_gv_grid_start", grid_start, 0);
    grid_valid = 1'b0;

    // ---- job A: corner everywhere ----
    dir_mode = 2'b10;
    start_job(8'hB4, 8'h1E, 1'b0);
    grid_valid = 1'b1; grid_score = 16'hFFFB;  // -5
    run_trace(60);
    chk("A_done_cycle", done_cyc, 13);
    chk("A_n_writes", n_wr, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("A_waddr[%0d]", i), wr_addr[i], i);
      chk($sformatf("A_wdata[%0d]", i), wr_data[i], exp_corner[i]);
      chk($sformatf("A_wcyc[%0d]", i), wr_cyc[i], 3*(i+1));
    end
    chk("A_path_len", path_len, 4);
    chk("A_score", score, 16'hFFFB);
    @(negedge clk);
    chk("A_post_done", done, 0);
    chk("A_post_ready", job_ready, 1);
    chk("A_post_path_len", path_len, 4);

    // ---- job B: left everywhere, job_valid held high throughout ----
    dir_mode = 2'b01;
    start_job(8'h5A, 8'hC3, 1'b1);
    grid_valid = 1'b1; grid_score = 16'd123;
    run_trace(80);
    chk("B_done_cycle", done_cyc, 22);
    chk("B_n_writes", n_wr, 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("B_waddr[%0d]", i), wr_addr[i], i);
      chk($sformatf("B_wdata[%0d]", i), wr_data[i], exp_left[i]);
    end
    chk("B_path_len", path_len, 7);
    chk("B_score", score, 16'd123);
    chk("B_no_ready_in_trace", jr_seen, 0);
    chk("B_no_restart_in_trace", gs_seen, 0);
    @(negedge clk);
    chk("B_done_plus1_start", grid_start, 0);
    chk("B_done_plus1_ready", job_ready, 1);
    @(negedge clk);
    chk("C_start_pulse", grid_start, 1);
    chk("C_grid_s1", grid_s1, 8'h5A);
    job_valid = 1'b0;
    @(negedge clk);

    // ---- job C: reset during TRACE_WAIT after two writes ----
    dir_mode = 2'b10;
    grid_valid = 1'b1; grid_score = 16'd77;
    run_trace(8);
    chk("C_writes_before_rst", n_wr, 2);
    reset = 1'b0;
    #1;
    chk("C_rst_wen", wen, 0);
    chk("C_rst_done", done, 0);
    chk("C_rst_ready", job_ready, 1);
    chk("C_rst_waddr", waddr, 0);
    chk("C_rst_path_len", path_len, 0);
    bad_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (done || wen) bad_cnt++;
    end
    reset = 1'b1;
    @(negedge clk);
    if (done || wen) bad_cnt++;
    chk("C_no_done_after_rst", bad_cnt, 0);

    // ---- job D: fresh job after the abort ----
    start_job(8'h27, 8'h9C, 1'b0);
    grid_valid = 1'b1; grid_score = 16'hFED4;  // -300
    run_trace(60);
    chk("D_done_cycle", done_cyc, 13);
    chk("D_n_writes", n_wr, 4);
    chk("D_first_waddr", wr_addr[0], 0);
    chk("D_first_wdata", wr_data[0], 16'h0303);
    chk("D_path_len", path_len, 4);
    chk("D_score", score, 16'hFED4);
    @(negedge clk);

    // ---- job E: grid never reports valid ----
    start_job(8'h11, 8'h22, 1'b0);
`ifdef NW_TRACE_TIMEOUT_EN
    err_cyc = -1; bad_cnt = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (wen || done) bad_cnt++;
      if (error) begin
        err_cyc = k;
        break;
      end
    end
    chk("E_error_cycle", err_cyc, 16);
    chk("E_no_writes", bad_cnt, 0);
    chk("E_idle_at_error", job_ready, 1);
    chk("E_path_len_held", path_len, 4);
    @(negedge clk);
    chk("E_error_one_cycle", error, 0);
`else
    bad_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (error || job_ready || wen || done) bad_cnt++;
    end
    chk("E_run_waits", bad_cnt, 0);
    grid_valid = 1'b1; grid_score = 16'd7;
    run_trace(60);
    chk("E_done_cycle", done_cyc, 13);
    chk("E_path_len", path_len, 4);
    chk("E_score", score, 16'd7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
